// File: rtl/gray_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_pkg : shared types, defaults and Gray-to-binary helper        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gray_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int REV_W_DEFAULT = 8;
  localparam int W_MAX         = 16;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Binary bit i is the XOR of all Gray bits from i upward.
  function automatic logic [W_MAX-1:0] gray2bin(input logic [W_MAX-1:0] g);
    logic [W_MAX-1:0] b;
    for (int i = 0; i < W_MAX; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin_comb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray2bin_comb : purely combinational W-bit Gray-to-binary convert  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gray2bin_comb #(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^(g >> i);
  end

endmodule
`default_nettype wire

// File: rtl/gray2bin_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray2bin_tracker : Gray sample -> binary position, step/dir/wrap   |
// | Optional parity check enabled by GRAY2BIN_PARITY_EN. Rev 1.0       |
// +--------------------------------------------------------------------+
module gray2bin_tracker
  import gray_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int REV_W = REV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     g_in,
  input  logic             g_valid,
  input  logic             clr_err,
`ifdef GRAY2BIN_PARITY_EN
  input  logic             g_par,
  output logic             par_err,
`endif
  output logic [W-1:0]     b_out,
  output logic             b_valid,
  output logic             step,
  output logic             dir,
  output logic             step_err,
  output logic             err_flag,
  output logic [REV_W-1:0] rev_cnt
);

  state_t             state_q, state_d;
  logic [W-1:0]       g_q, g_d;
  logic               v1_q, v1_d;
  logic [W-1:0]       b_out_q, b_out_d;
  logic               b_valid_q, b_valid_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               step_err_q, step_err_d;
  logic               err_flag_q, err_flag_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;

  logic [W-1:0]       w_b_new;
  logic [W-1:0]       w_diff;
  logic               w_up, w_dn, w_same, w_bad, w_illegal, w_eval;

  gray2bin_comb #(.W(W)) u_conv (
    .g (g_q),
    .b (w_b_new)
  );

`ifdef GRAY2BIN_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic par_err_q, par_err_d;

  // Even parity over {g_par, g_in}: an odd total marks a corrupt sample.
  assign par_bad_d = g_valid & (^{g_par, g_in});
  assign par_err_d = v1_q & par_bad_q;
  assign w_bad     = par_bad_q;
  assign par_err   = par_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
    end
  end
`else
  assign w_bad = 1'b0;
`endif

  assign g_d       = g_valid ? g_in : g_q;
  assign v1_d      = g_valid;
  assign w_diff    = w_b_new - b_out_q;
  assign w_up      = (w_diff == W'(1));
  assign w_dn      = (w_diff == {W{1'b1}});
  assign w_same    = (w_diff == '0);
  assign w_illegal = w_bad | ~(w_up | w_dn | w_same);
  // A clr_err on the completing edge suppresses any step evaluation.
  assign w_eval    = v1_q & ~clr_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_err) begin
      state_d = INIT;
    end else if (v1_q) begin
      unique case (state_q)
        INIT:    state_d = w_bad ? ERROR : TRACK;
        TRACK:   state_d = w_illegal ? ERROR : TRACK;
        ERROR:   state_d = ERROR;
        default: state_d = INIT;
      endcase
    end
  end

  always_comb begin
    b_out_d    = v1_q ? w_b_new : b_out_q;
    b_valid_d  = v1_q;
    step_d     = 1'b0;
    step_err_d = 1'b0;
    dir_d      = dir_q;
    err_flag_d = err_flag_q;
    rev_cnt_d  = rev_cnt_q;
    if (w_eval) begin
      unique case (state_q)
        INIT: begin
          step_err_d = w_bad;
        end
        TRACK: begin
          if (w_illegal) begin
            step_err_d = 1'b1;
          end else if (w_up) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            if (&b_out_q) rev_cnt_d = rev_cnt_q + REV_W'(1);
          end else if (w_dn) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            if (~|b_out_q) rev_cnt_d = rev_cnt_q - REV_W'(1);
          end
        end
        default: ;
      endcase
    end
    if (step_err_d) err_flag_d = 1'b1;
    if (clr_err) begin
      err_flag_d = 1'b0;
      rev_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q        <= '0;
      v1_q       <= 1'b0;
      b_out_q    <= '0;
      b_valid_q  <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      step_err_q <= 1'b0;
      err_flag_q <= 1'b0;
      rev_cnt_q  <= '0;
    end else begin
      g_q        <= g_d;
      v1_q       <= v1_d;
      b_out_q    <= b_out_d;
      b_valid_q  <= b_valid_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      step_err_q <= step_err_d;
      err_flag_q <= err_flag_d;
      rev_cnt_q  <= rev_cnt_d;
    end
  end

  assign b_out    = b_out_q;
  assign b_valid  = b_valid_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign step_err = step_err_q;
  assign err_flag = err_flag_q;
  assign rev_cnt  = rev_cnt_q;

endmodule
`default_nettype wire
